// File: rtl/egd_stream_ctrl.sv
// Host-side sequencer: buffers 16-bit words, serializes them MSB-first to the Exp-Golomb decoder.
// Optional consumed-bit counter enabled by defining EGD_BITCNT_EN.
module egd_stream_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int WORD_W     = 16,
    parameter int SYM_W      = 8
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [WORD_W-1:0]           host_wdata,
    input  logic [1:0]                  host_cmd,
    input  logic                        host_stb,
    input  logic                        ctrl_en,
    output logic                        dec_bit,
    output logic                        dec_bit_vld,
    input  logic                        dec_bit_rdy,
    output logic                        dec_clr,
    input  logic [SYM_W-1:0]            dec_sym,
    input  logic                        dec_sym_vld,
    output logic [SYM_W-1:0]            sym_out,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [3:0]                  status,
    output logic [15:0]                 bit_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(WORD_W);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_B  = BW'(WORD_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            r_state;
    logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_rd;
    logic [AW-1:0]     r_wr;
    logic [LW-1:0]     r_level;
    logic [WORD_W-1:0] r_shift;
    logic [BW-1:0]     r_bitcnt;
    logic              r_stb_q;
    logic              r_clr;
    logic [SYM_W-1:0]  r_sym;
    logic              r_sym_new;
    logic              r_ovf;

    logic w_go, w_push, w_flush, w_ack;
    logic w_full, w_empty, w_accept, w_last, w_pop, w_wr;

    assign w_go     = host_stb & ~r_stb_q;
    assign w_push   = w_go & (host_cmd == 2'b01);
    assign w_flush  = w_go & (host_cmd == 2'b10);
    assign w_ack    = w_go & (host_cmd == 2'b11);
    assign w_full   = (r_level == DEPTH_L);
    assign w_empty  = (r_level == '0);
    assign w_accept = dec_bit_vld & dec_bit_rdy;
    assign w_last   = (r_state == SHIFT) & w_accept & (r_bitcnt == LAST_B);
    // A pop is only taken when idle or exactly as the last bit of a word leaves.
    assign w_pop    = ~w_empty & ctrl_en & ~w_flush
                    & ((r_state == IDLE) | w_last);
    assign w_wr     = w_push & ~w_full;

    assign dec_bit     = r_shift[WORD_W-1];
    assign dec_bit_vld = (r_state == SHIFT) & ctrl_en;
    assign dec_clr     = r_clr;
    assign sym_out     = r_sym;
    assign fifo_level  = r_level;
    assign status      = {r_ovf, r_sym_new,
                          (r_state == SHIFT) | ~w_empty, w_full};

    always_ff @(posedge wb_clk_i) begin
        if (w_wr) r_mem[r_wr] <= host_wdata;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= IDLE;
            r_rd      <= '0;
            r_wr      <= '0;
            r_level   <= '0;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_stb_q   <= 1'b0;
            r_clr     <= 1'b0;
            r_sym     <= '0;
            r_sym_new <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_stb_q <= host_stb;
            r_clr   <= w_flush;
            if (w_flush) begin
                r_state  <= IDLE;
                r_rd     <= '0;
                r_wr     <= '0;
                r_level  <= '0;
                r_shift  <= '0;
                r_bitcnt <= '0;
            end else begin
                if (w_wr)  r_wr <= r_wr + AW'(1);
                if (w_pop) r_rd <= r_rd + AW'(1);
                r_level <= r_level + LW'(w_wr) - LW'(w_pop);
                case (r_state)
                    IDLE: begin
                        if (w_pop) begin
                            r_shift  <= r_mem[r_rd];
                            r_bitcnt <= '0;
                            r_state  <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (w_pop) begin
                            r_shift  <= r_mem[r_rd];
                            r_bitcnt <= '0;
                        end else if (w_accept) begin
                            r_shift  <= r_shift << 1;
                            r_bitcnt <= r_bitcnt + BW'(1);
                            if (w_last) r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
            // Symbol is always overwritten; ovf flags a lost unacknowledged one.
            if (dec_sym_vld) begin
                r_sym     <= dec_sym;
                r_sym_new <= 1'b1;
                if (w_ack)          r_ovf <= 1'b0;
                else if (r_sym_new) r_ovf <= 1'b1;
            end else if (w_ack) begin
                r_sym_new <= 1'b0;
                r_ovf     <= 1'b0;
            end
            if (w_push && w_full) r_ovf <= 1'b1;
        end
    end

`ifdef EGD_BITCNT_EN
    logic [15:0] r_bit_count;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || w_flush) r_bit_count <= '0;
        else if (w_accept)       r_bit_count <= r_bit_count + 16'd1;
    end
    assign bit_count = r_bit_count;
`else
    assign bit_count = 16'h0000;
`endif

endmodule

// File: tb/tb_egd_stream_ctrl.sv
// Bench for egd_stream_ctrl: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_egd_stream_ctrl;
    localparam int D = 4;
`ifdef EGD_BITCNT_EN
    localparam bit BC_EN = 1'b1;
`else
    localparam bit BC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [15:0] host_wdata = '0;
    logic [1:0]  host_cmd = '0;
    logic        host_stb = 1'b0;
    logic        ctrl_en = 1'b0;
    logic        dec_bit, dec_bit_vld, dec_clr;
    logic        dec_bit_rdy = 1'b0;
    logic [7:0]  dec_sym = '0;
    logic        dec_sym_vld = 1'b0;
    logic [7:0]  sym_out;
    logic [2:0]  fifo_level;
    logic [3:0]  status;
    logic [15:0] bit_count;

    always #5 clk = ~clk;

    egd_stream_ctrl #(.FIFO_DEPTH(D), .WORD_W(16), .SYM_W(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
        .host_wdata(host_wdata), .host_cmd(host_cmd),
        .host_stb(host_stb), .ctrl_en(ctrl_en),
        .dec_bit(dec_bit), .dec_bit_vld(dec_bit_vld),
        .dec_bit_rdy(dec_bit_rdy), .dec_clr(dec_clr),
        .dec_sym(dec_sym), .dec_sym_vld(dec_sym_vld),
        .sym_out(sym_out), .fifo_level(fifo_level),
        .status(status), .bit_count(bit_count)
    );

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    logic [63:0] cap = '0;
    int cap_n = 0;

    // Reference model: a word queue plus the bits still owed from the current word.
    logic [15:0] m_fifo[$];
    bit          m_bits[$];
    logic        m_stbq = 0, m_clr = 0, m_new = 0, m_ovf = 0;
    logic [7:0]  m_sym = '0;
    logic [15:0] m_cnt = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic go, push, flush, ack, acc;
        logic [15:0] w;
        int pre;
        if (wb_rst_i) begin
            m_fifo.delete(); m_bits.delete();
            m_stbq = 0; m_clr = 0; m_new = 0; m_ovf = 0;
            m_sym = '0; m_cnt = '0;
            return;
        end
        go    = host_stb && !m_stbq;
        push  = go && host_cmd == 2'b01;
        flush = go && host_cmd == 2'b10;
        ack   = go && host_cmd == 2'b11;
        acc   = m_bits.size() > 0 && ctrl_en && dec_bit_rdy;
        pre   = m_fifo.size();
        m_stbq = host_stb;
        m_clr  = flush;
        if (dec_sym_vld) begin
            m_sym = dec_sym;
            if (ack) m_ovf = 0;
            else if (m_new) m_ovf = 1;
            m_new = 1;
        end else if (ack) begin
            m_new = 0; m_ovf = 0;
        end
        if (push && pre == D) m_ovf = 1;
        if (flush) begin
            m_fifo.delete(); m_bits.delete(); m_cnt = '0;
        end else begin
            if (acc) begin
                void'(m_bits.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (m_bits.size() == 0 && pre > 0 && ctrl_en) begin
                w = m_fifo.pop_front();
                for (int i = 15; i >= 0; i--) m_bits.push_back(w[i]);
            end
            if (push && pre < D) m_fifo.push_back(host_wdata);
        end
    endtask

    always @(posedge clk) begin
        #1;
        model_step();
    end

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            chk("dec_bit", dec_bit, m_bits.size() > 0 ? m_bits[0] : 1'b0);
            chk("dec_bit_vld", dec_bit_vld, m_bits.size() > 0 && ctrl_en);
            chk("dec_clr", dec_clr, m_clr);
            chk("sym_out", sym_out, m_sym);
            chk("fifo_level", fifo_level, m_fifo.size());
            chk("status", status, {m_ovf, m_new,
                m_bits.size() > 0 || m_fifo.size() > 0, m_fifo.size() == D});
            chk("bit_count", bit_count, BC_EN ? m_cnt : 16'h0);
        end
        if (dec_bit_vld === 1'b1 && dec_bit_rdy && !wb_rst_i) begin
            cap = {cap[62:0], dec_bit};
            cap_n++;
        end
    end

    task automatic cmd(input logic [1:0] c, input logic [15:0] w);
        @(negedge clk);
        host_cmd = c; host_wdata = w; host_stb = 1'b1;
        @(negedge clk);
        host_stb = 1'b0; host_cmd = 2'b00;
    endtask

    task automatic wait_cap(input int n, input int budget, input string nm);
        int t = 0;
        while (cap_n < n && t < budget) begin
            @(negedge clk); #3; t++;
        end
        chk(nm, cap_n >= n, 1'b1);
    endtask

    logic [15:0] w5 [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};

    initial begin
        wb_rst_i = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        wb_rst_i = 1'b0;
        #3;
        chk("rst level", fifo_level, 3'd0);
        chk("rst status", status, 4'h0);
        chk("rst vld", dec_bit_vld, 1'b0);
        chk("rst bitcnt", bit_count, 16'h0);

        // Single word, latency and bit order
        ctrl_en = 1'b1; dec_bit_rdy = 1'b1; cap_n = 0;
        cmd(2'b01, 16'hA5C3);
        #3;
        chk("t1 level", fifo_level, 3'd1);
        chk("t1 vld early", dec_bit_vld, 1'b0);
        @(negedge clk); #3;
        chk("t1 vld", dec_bit_vld, 1'b1);
        wait_cap(16, 40, "t1 timeout");
        chk("t1 bits", cap[15:0], 16'hA5C3);
        @(negedge clk); #3;
        chk("t1 idle", dec_bit_vld, 1'b0);
        chk("t1 busy", status[1], 1'b0);
        chk("t1 bitcnt", bit_count, BC_EN ? 16'd16 : 16'd0);

        // Overflow of a paused FIFO
        @(negedge clk); ctrl_en = 1'b0;
        for (int i = 0; i < 5; i++) cmd(2'b01, w5[i]);
        #3;
        chk("t2 level", fifo_level, 3'd4);
        chk("t2 full", status[0], 1'b1);
        chk("t2 ovf", status[3], 1'b1);
        cmd(2'b11, 16'h0);
        #3;
        chk("t2 ack ovf", status[3], 1'b0);
        @(negedge clk); ctrl_en = 1'b1; cap_n = 0;
        wait_cap(64, 150, "t2 timeout");
        chk("t2 bits", cap, 64'h1111_2222_3333_4444);
        @(negedge clk); #3;
        chk("t2 drained", status, 4'h0);
        repeat (3) @(negedge clk);
        chk("t2 no 5th", cap_n, 64'd64);

        // Two words under a toggling ready
        @(negedge clk); ctrl_en = 1'b0; dec_bit_rdy = 1'b0;
        cmd(2'b01, 16'hF00F);
        cmd(2'b01, 16'h3CA5);
        @(negedge clk); ctrl_en = 1'b1; cap_n = 0;
        begin
            int t = 0;
            while (cap_n < 32 && t < 200) begin
                @(negedge clk); dec_bit_rdy = ~dec_bit_rdy; #3; t++;
            end
        end
        chk("t3 timeout", cap_n >= 32, 1'b1);
        chk("t3 bits", cap[31:0], 32'hF00F_3CA5);
        @(negedge clk); dec_bit_rdy = 1'b1;
        repeat (2) @(negedge clk);

        // Flush mid-word
        dec_bit_rdy = 1'b0;
        cmd(2'b01, 16'hFFFF);
        @(negedge clk); dec_bit_rdy = 1'b1;
        repeat (7) @(negedge clk);
        dec_bit_rdy = 1'b0;
        cmd(2'b10, 16'h0);
        #3;
        chk("t4 clr", dec_clr, 1'b1);
        chk("t4 vld", dec_bit_vld, 1'b0);
        chk("t4 level", fifo_level, 3'd0);
        chk("t4 bitcnt", bit_count, 16'h0);
        @(negedge clk); #3;
        chk("t4 clr once", dec_clr, 1'b0);

        // Symbol capture and overflow
        cmd(2'b11, 16'h0);
        @(negedge clk); dec_sym = 8'h03; dec_sym_vld = 1'b1;
        @(negedge clk); dec_sym = 8'h07;
        @(negedge clk); dec_sym_vld = 1'b0;
        #3;
        chk("t5 sym", sym_out, 8'h07);
        chk("t5 flags", status[3:2], 2'b11);
        @(negedge clk);
        host_cmd = 2'b11; host_stb = 1'b1;
        dec_sym = 8'h01; dec_sym_vld = 1'b1;
        @(negedge clk);
        host_stb = 1'b0; host_cmd = 2'b00; dec_sym_vld = 1'b0;
        #3;
        chk("t5 sym ack", sym_out, 8'h01);
        chk("t5 flags ack", status[3:2], 2'b01);

        // Held strobe executes once
        @(negedge clk); ctrl_en = 1'b0;
        host_cmd = 2'b01; host_wdata = 16'hBEEF; host_stb = 1'b1;
        repeat (10) @(negedge clk);
        host_stb = 1'b0; host_cmd = 2'b00;
        #3;
        chk("t6 level", fifo_level, 3'd1);

        // Reset mid-shift
        @(negedge clk); ctrl_en = 1'b1; dec_bit_rdy = 1'b1;
        repeat (4) @(negedge clk);
        wb_rst_i = 1'b1;
        @(negedge clk); wb_rst_i = 1'b0;
        #3;
        chk("t7 clr", dec_clr, 1'b0);
        chk("t7 vld", dec_bit_vld, 1'b0);
        chk("t7 status", status, 4'h0);
        chk("t7 sym", sym_out, 8'h00);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
